// File: rtl/gray_enc_pkg.sv
// Shared types and helpers for the Gray-encoder arbiter slice.
// The optional encoder checker is enabled by defining GRAY_ENC_CHECK_EN.
package gray_enc_pkg;

  localparam int VAL_W   = 3;
  localparam int THERM_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic [VAL_W-1:0] to_gray(input logic [VAL_W-1:0] val);
    return val ^ (val >> 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at rr_ptr and wraps from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    win,
  output logic               any_req
);

  int              sum;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt     = '0;
    win     = '0;
    any_req = |req;
    found   = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (!found && req[idx]) begin
        found    = 1'b1;
        win      = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_enc_arbiter.sv
// Round-robin sharing of one combinational Gray encoder among NUM_REQ requesters.
// Define GRAY_ENC_CHECK_EN to add the sticky err output and encoder checker.
//
// state | meaning
// IDLE  | waiting for a request; grant pulses combinationally here
// ISSUE | enc_en high, shared encoder result captured on the edge
// RESP  | response held on rsp_* until rsp_ready
module gray_enc_arbiter
  import gray_enc_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [VAL_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [VAL_W-1:0]         enc_deci,
  output logic                     enc_en,
  input  logic [VAL_W-1:0]         enc_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [VAL_W-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
`ifdef GRAY_ENC_CHECK_EN
  ,
  output logic                     err
`endif
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_win;
  logic                any_req;
  logic [VAL_W-1:0]    sel_data;
  logic [ID_W-1:0]     ptr_nxt;
  logic                take;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .win     (arb_win),
    .any_req (any_req)
  );

  assign sel_data = req_data[int'(arb_win)*VAL_W +: VAL_W];
  assign ptr_nxt  = (arb_win == ID_W'(NUM_REQ-1)) ? '0 : arb_win + ID_W'(1);
  assign take     = (state == IDLE) && any_req;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt       = arb_gnt;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // enc_en is registered so it is glitch-free for exactly the ISSUE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      enc_deci  <= '0;
      enc_en    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      enc_en <= (state_nxt == ISSUE);
      if (take) begin
        enc_deci <= sel_data;
        rsp_id   <= arb_win;
        rr_ptr   <= ptr_nxt;
      end
      if (state == ISSUE) begin
        rsp_data  <= enc_out;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef GRAY_ENC_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (state == ISSUE && enc_out != to_gray(enc_deci))
      err <= 1'b1;
  end
`endif

endmodule
